mux_2x1_arbiter: RTL and testbench
==================================

Name: mux_2x1_arbiter

Overview:
Two-requester arbiter that owns the select line of a shared 2:1 data channel (sel=0 passes A, sel=1 passes B). It grants one requester at a time and limits burst length with a hold limit. Round-robin order applies on ties. The granted beat is passed through a registered output stage toward the downstream consumer.

Parameters:
DATA_W, 8, width of data_a, data_b and out_data
MAX_HOLD, 4, max beats per grant while the other side is requesting; 0 = unlimited

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous, active-high reset
req_a  input  1  requester A wants the channel; held high for the whole burst
req_b  input  1  requester B wants the channel; held high for the whole burst
data_a  input  DATA_W  requester A data
data_b  input  DATA_W  requester B data
gnt_a  output  1  A owns the channel (registered)
gnt_b  output  1  B owns the channel (registered)
sel  output  1  mux select; 1 exactly when state is GRANT_B
out_data  output  DATA_W  registered muxed data
out_valid  output  1  out_data holds a granted beat

Behaviour:
- Reset (async, rst=1): state=IDLE, gnt_a=gnt_b=0, sel=0, last_gnt=B (A wins the first tie), hold_cnt=0, out_data=0, out_valid=0. Reset mid-burst drops the grant immediately; the interrupted beat is not emitted.
- States: IDLE, GRANT_A, GRANT_B. gnt_a, gnt_b and sel decode directly from the state register. gnt_a and gnt_b are never high together.
- Beat: a cycle with (gnt_a & req_a) or (gnt_b & req_b).
- hold_cnt: width $clog2(MAX_HOLD+1), minimum 1. Counts beats in the current grant and saturates at MAX_HOLD. Clears to 0 on every grant change and in IDLE.
- IDLE transitions:
  - req_a only -> GRANT_A.
  - req_b only -> GRANT_B.
  - Both -> the side not equal to last_gnt.
  - Neither -> stay in IDLE.
- GRANT_X transitions (Y = the other side):
  - req_X=0: go to GRANT_Y if req_Y=1, else IDLE. No idle bubble on handover.
  - req_X=1, MAX_HOLD!=0, the current cycle is beat number MAX_HOLD (hold_cnt==MAX_HOLD-1), req_Y=1: go to GRANT_Y (forced rotation).
  - Otherwise stay. With req_Y=0, X keeps the channel indefinitely and hold_cnt saturates.
- last_gnt updates to X on every entry to GRANT_X.
- Latency:
  - Grant asserts 1 cycle after the request is sampled.
  - out_data/out_valid follow the beat by 1 cycle: out_valid <= beat; out_data <= sel ? data_b : data_a, loaded only on beats. out_data holds its value otherwise.
- Requests are level-sensitive. Dropping req while granted ends the burst; that cycle is not a beat.

Optional Feature:
Macro: MUX_ARB_FIXED_PRIO_EN
- Defined: on a tie, A always wins, in IDLE and after a grant release. MAX_HOLD rotation still forces A -> B when B is waiting, and B -> A likewise. last_gnt is unused.
- Undefined: round-robin tie-break via last_gnt, as described above.

Test Plan:
- Reset: rst=1 mid-operation with req_a=req_b=1 -> every output 0 within the same cycle. Release rst with both requesting -> gnt_a=1 on the first edge.
- Single requester: req_a=1 for 10 cycles, data_a=0x10..0x19, req_b=0 -> gnt_a continuous. out_valid high for 10 cycles starting 1 cycle after the first beat; out_data 0x10..0x19 in order.
- Forced rotation: MAX_HOLD=4, both requesting continuously -> grants alternate every 4 beats: A,A,A,A,B,B,B,B,A... No cycle without a grant; sel tracks gnt_b.
- Handover: gnt_a active, req_a drops while req_b=1 -> gnt_b=1 on the next edge with no IDLE cycle; last A beat and first B beat appear back-to-back on out_data.
- Tie from IDLE after a B burst: both raise req simultaneously -> A granted. With MUX_ARB_FIXED_PRIO_EN defined and a prior A burst -> A still granted.
- Unlimited hold: MAX_HOLD=0, req_a held 20 cycles, req_b=1 -> A keeps the grant all 20 cycles; B is granted the cycle after req_a drops.

Source files
------------

// File: rtl/mux_2x1_arbiter_if.sv
// Channel bundle for the two-requester arbiter: request/data lines from the
// requesters and the grant, select and registered data toward the consumer.
// The master modport is the requester/consumer side; slave is the arbiter.
interface mux_2x1_arbiter_if #(
  parameter int DATA_W = 8
);
  logic              req_a;
  logic              req_b;
  logic [DATA_W-1:0] data_a;
  logic [DATA_W-1:0] data_b;
  logic              gnt_a;
  logic              gnt_b;
  logic              sel;
  logic [DATA_W-1:0] out_data;
  logic              out_valid;

  modport master (
    output req_a, req_b, data_a, data_b,
    input  gnt_a, gnt_b, sel, out_data, out_valid
  );

  modport slave (
    input  req_a, req_b, data_a, data_b,
    output gnt_a, gnt_b, sel, out_data, out_valid
  );
endinterface

// File: rtl/mux_2x1_arbiter.sv
// Two-requester arbiter owning the select of a shared 2:1 data channel.
// Grants one side at a time, caps a burst at MAX_HOLD beats while the other
// side waits (0 = no cap), and registers the granted beat toward the consumer.
// Optional macro MUX_ARB_FIXED_PRIO_EN: ties always go to A instead of
// alternating through the last-granted side.
module mux_2x1_arbiter #(
  parameter int DATA_W   = 8,
  parameter int MAX_HOLD = 4
) (
  input  logic              clk,
  input  logic              rst,
  mux_2x1_arbiter_if.slave  bus
);

  localparam int CNT_W = (MAX_HOLD < 1) ? 1 : $clog2(MAX_HOLD + 1);
  localparam logic [CNT_W-1:0] HOLD_LAST = (MAX_HOLD == 0) ? '0 : CNT_W'(MAX_HOLD - 1);
  localparam logic [CNT_W-1:0] HOLD_SAT  = CNT_W'(MAX_HOLD);
  localparam bit HOLD_EN = (MAX_HOLD != 0);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT_A = 2'd1,
    GRANT_B = 2'd2
  } state_t;

  state_t            state;
  state_t            state_nxt;
  logic [CNT_W-1:0]  hold_cnt;
  logic              beat;
  logic              hold_hit;
  logic              tie_pick_b;
  logic              sel_int;
  logic [DATA_W-1:0] mux_data;

  assign sel_int  = (state == GRANT_B);
  assign mux_data = sel_int ? bus.data_b : bus.data_a;
  assign beat     = ((state == GRANT_A) && bus.req_a) || ((state == GRANT_B) && bus.req_b);
  // The current beat is the last one allowed before the waiting side takes over
  assign hold_hit = HOLD_EN && (hold_cnt == HOLD_LAST);

  assign bus.gnt_a = (state == GRANT_A);
  assign bus.gnt_b = (state == GRANT_B);
  assign bus.sel   = sel_int;

`ifdef MUX_ARB_FIXED_PRIO_EN
  assign tie_pick_b = 1'b0;
`else
  logic last_gnt;

  assign tie_pick_b = ~last_gnt;

  // Remember which side was granted most recently (1 = B) so ties alternate
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_gnt <= 1'b1;
    end else if ((state_nxt == GRANT_A) && (state != GRANT_A)) begin
      last_gnt <= 1'b0;
    end else if ((state_nxt == GRANT_B) && (state != GRANT_B)) begin
      last_gnt <= 1'b1;
    end
  end
`endif

  // Grant state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next grant: tie-break from idle, immediate handover on release, forced rotation at the hold cap
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (bus.req_a && bus.req_b) begin
          state_nxt = tie_pick_b ? GRANT_B : GRANT_A;
        end else if (bus.req_a) begin
          state_nxt = GRANT_A;
        end else if (bus.req_b) begin
          state_nxt = GRANT_B;
        end
      end
      GRANT_A: begin
        if (!bus.req_a) begin
          state_nxt = bus.req_b ? GRANT_B : IDLE;
        end else if (hold_hit && bus.req_b) begin
          state_nxt = GRANT_B;
        end
      end
      GRANT_B: begin
        if (!bus.req_b) begin
          state_nxt = bus.req_a ? GRANT_A : IDLE;
        end else if (hold_hit && bus.req_a) begin
          state_nxt = GRANT_A;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Beats within the current grant, restarting on every grant change and saturating at the cap
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hold_cnt <= '0;
    end else if ((state_nxt != state) || (state_nxt == IDLE)) begin
      hold_cnt <= '0;
    end else if (beat && (hold_cnt != HOLD_SAT)) begin
      hold_cnt <= hold_cnt + CNT_W'(1);
    end
  end

  // Registered output stage: data is captured only on beats and held otherwise
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.out_valid <= 1'b0;
      bus.out_data  <= '0;
    end else begin
      bus.out_valid <= beat;
      if (beat) begin
        bus.out_data <= mux_data;
      end
    end
  end

endmodule

// File: tb/tb_mux_2x1_arbiter.sv
// Self-checking bench for mux_2x1_arbiter: one instance with a hold cap of 4
// and one with an unlimited hold, sharing clock and reset. Expected beats are
// queued as they are driven and compared when out_valid presents them.
module tb_mux_2x1_arbiter;

  localparam int DATA_W = 8;
`ifdef MUX_ARB_FIXED_PRIO_EN
  localparam bit FIXED_PRIO = 1'b1;
`else
  localparam bit FIXED_PRIO = 1'b0;
`endif

  logic clk;
  logic rst;
  int   n_checks;
  int   n_fail;
  logic [DATA_W-1:0] exp_q[$];
  logic [DATA_W-1:0] exp0_q[$];

  mux_2x1_arbiter_if #(.DATA_W(DATA_W)) bus ();
  mux_2x1_arbiter_if #(.DATA_W(DATA_W)) bus0 ();

  mux_2x1_arbiter #(.DATA_W(DATA_W), .MAX_HOLD(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  mux_2x1_arbiter #(.DATA_W(DATA_W), .MAX_HOLD(0)) dut0 (
    .clk (clk),
    .rst (rst),
    .bus (bus0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [DATA_W-1:0] exp;
    rst = 1'b1;
    bus.req_a = 1'b0;  bus.req_b = 1'b0;  bus.data_a = '0;  bus.data_b = '0;
    bus0.req_a = 1'b0; bus0.req_b = 1'b0; bus0.data_a = '0; bus0.data_b = '0;
    repeat (3) tick();
    n_checks++;
    if ({bus.gnt_a, bus.gnt_b, bus.sel, bus.out_valid, bus.out_data} !== '0) begin
      n_fail++;
      $display("[TB] FAIL reset_state: gnt_a=%b gnt_b=%b sel=%b valid=%b data=%h, required all 0",
               bus.gnt_a, bus.gnt_b, bus.sel, bus.out_valid, bus.out_data);
    end
    rst = 1'b0;
    bus.req_a = 1'b1; bus.req_b = 1'b1; bus.data_a = 8'h5A; bus.data_b = 8'hA5;
    tick();
    n_checks++;
    if ({bus.gnt_a, bus.gnt_b} !== 2'b10) begin
      n_fail++;
      $display("[TB] FAIL reset_first_tie: gnt_a/gnt_b=%b%b, required 10", bus.gnt_a, bus.gnt_b);
    end
    exp_q.push_back(8'h5A);
    tick();
    n_checks++;
    if (bus.out_valid !== 1'b1 || exp_q.size() == 0) begin
      n_fail++;
      $display("[TB] FAIL reset_beat_valid: valid=%b queued=%0d, required valid=1", bus.out_valid, exp_q.size());
    end else begin
      exp = exp_q.pop_front();
      n_checks++;
      if (bus.out_data !== exp) begin
        n_fail++;
        $display("[TB] FAIL reset_beat_data: data=%h, required %h", bus.out_data, exp);
      end
    end
    rst = 1'b1;
    #1;
    n_checks++;
    if ({bus.gnt_a, bus.gnt_b, bus.sel, bus.out_valid, bus.out_data} !== '0) begin
      n_fail++;
      $display("[TB] FAIL reset_midburst: gnt_a=%b gnt_b=%b sel=%b valid=%b data=%h, required all 0",
               bus.gnt_a, bus.gnt_b, bus.sel, bus.out_valid, bus.out_data);
    end
    tick();
    rst = 1'b0;
    tick();
    n_checks++;
    if ({bus.gnt_a, bus.gnt_b} !== 2'b10) begin
      n_fail++;
      $display("[TB] FAIL reset_release_tie: gnt_a/gnt_b=%b%b, required 10", bus.gnt_a, bus.gnt_b);
    end
    bus.req_a = 1'b0; bus.req_b = 1'b0;
    tick();
    n_checks++;
    if ({bus.gnt_a, bus.gnt_b, bus.out_valid} !== 3'b000) begin
      n_fail++;
      $display("[TB] FAIL reset_to_idle: gnt_a/gnt_b/valid=%b%b%b, required 000", bus.gnt_a, bus.gnt_b, bus.out_valid);
    end
  endtask

  task automatic test_single_requester();
    logic [DATA_W-1:0] exp;
    bus.req_a = 1'b1; bus.req_b = 1'b0; bus.data_a = 8'h10;
    tick();
    n_checks++;
    if (bus.gnt_a !== 1'b1 || bus.out_valid !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL single_grant: gnt_a=%b valid=%b, required gnt_a=1 valid=0", bus.gnt_a, bus.out_valid);
    end
    for (int i = 0; i < 10; i++) begin
      bus.data_a = 8'h10 + 8'(i);
      exp_q.push_back(bus.data_a);
      tick();
      n_checks++;
      if (bus.gnt_a !== 1'b1 || bus.out_valid !== 1'b1 || exp_q.size() == 0) begin
        n_fail++;
        $display("[TB] FAIL single_beat %0d: gnt_a=%b valid=%b queued=%0d, required gnt_a=1 valid=1",
                 i, bus.gnt_a, bus.out_valid, exp_q.size());
      end else begin
        exp = exp_q.pop_front();
        n_checks++;
        if (bus.out_data !== exp) begin
          n_fail++;
          $display("[TB] FAIL single_data %0d: data=%h, required %h", i, bus.out_data, exp);
        end
      end
    end
    bus.req_a = 1'b0;
    tick();
    n_checks++;
    if ({bus.gnt_a, bus.gnt_b, bus.out_valid} !== 3'b000 || bus.out_data !== 8'h19) begin
      n_fail++;
      $display("[TB] FAIL single_release: gnt_a/gnt_b/valid=%b%b%b data=%h, required 000 data=19",
               bus.gnt_a, bus.gnt_b, bus.out_valid, bus.out_data);
    end
  endtask

  task automatic test_rotation();
    logic [DATA_W-1:0] exp;
    logic cur_b;
    int   cnt;
    // The previous grant was A, so round-robin hands the tie to B
    cur_b = FIXED_PRIO ? 1'b0 : 1'b1;
    cnt = 0;
    bus.req_a = 1'b1; bus.req_b = 1'b1;
    tick();
    for (int i = 0; i < 16; i++) begin
      n_checks++;
      if ({bus.gnt_a, bus.gnt_b, bus.sel} !== {~cur_b, cur_b, cur_b}) begin
        n_fail++;
        $display("[TB] FAIL rotation_grant %0d: gnt_a/gnt_b/sel=%b%b%b, required %b%b%b",
                 i, bus.gnt_a, bus.gnt_b, bus.sel, ~cur_b, cur_b, cur_b);
      end
      bus.data_a = 8'hA0 + 8'(i);
      bus.data_b = 8'hB0 + 8'(i);
      exp_q.push_back(cur_b ? bus.data_b : bus.data_a);
      tick();
      n_checks++;
      if (bus.out_valid !== 1'b1 || exp_q.size() == 0) begin
        n_fail++;
        $display("[TB] FAIL rotation_valid %0d: valid=%b queued=%0d, required valid=1", i, bus.out_valid, exp_q.size());
      end else begin
        exp = exp_q.pop_front();
        n_checks++;
        if (bus.out_data !== exp) begin
          n_fail++;
          $display("[TB] FAIL rotation_data %0d: data=%h, required %h", i, bus.out_data, exp);
        end
      end
      cnt++;
      if (cnt == 4) begin
        cur_b = ~cur_b;
        cnt = 0;
      end
    end
    bus.req_a = 1'b0; bus.req_b = 1'b0;
    tick();
    n_checks++;
    if ({bus.gnt_a, bus.gnt_b, bus.out_valid} !== 3'b000) begin
      n_fail++;
      $display("[TB] FAIL rotation_release: gnt_a/gnt_b/valid=%b%b%b, required 000", bus.gnt_a, bus.gnt_b, bus.out_valid);
    end
  endtask

  task automatic test_handover();
    logic [DATA_W-1:0] exp;
    bus.req_a = 1'b1; bus.req_b = 1'b0;
    tick();
    n_checks++;
    if ({bus.gnt_a, bus.gnt_b} !== 2'b10) begin
      n_fail++;
      $display("[TB] FAIL handover_grant_a: gnt_a/gnt_b=%b%b, required 10", bus.gnt_a, bus.gnt_b);
    end
    bus.req_b = 1'b1;
    for (int j = 0; j < 2; j++) begin
      bus.data_a = 8'h31 + 8'(j);
      bus.data_b = 8'hEE;
      exp_q.push_back(bus.data_a);
      tick();
      n_checks++;
      if (bus.out_valid !== 1'b1 || exp_q.size() == 0) begin
        n_fail++;
        $display("[TB] FAIL handover_a_valid %0d: valid=%b queued=%0d, required valid=1", j, bus.out_valid, exp_q.size());
      end else begin
        exp = exp_q.pop_front();
        n_checks++;
        if (bus.out_data !== exp) begin
          n_fail++;
          $display("[TB] FAIL handover_a_data %0d: data=%h, required %h", j, bus.out_data, exp);
        end
      end
    end
    bus.req_a = 1'b0;
    tick();
    n_checks++;
    if ({bus.gnt_a, bus.gnt_b, bus.sel, bus.out_valid} !== 4'b0110 || bus.out_data !== 8'h32) begin
      n_fail++;
      $display("[TB] FAIL handover_switch: gnt_a/gnt_b/sel/valid=%b%b%b%b data=%h, required 0110 data=32",
               bus.gnt_a, bus.gnt_b, bus.sel, bus.out_valid, bus.out_data);
    end
    bus.data_b = 8'h41;
    exp_q.push_back(bus.data_b);
    tick();
    n_checks++;
    if (bus.out_valid !== 1'b1 || exp_q.size() == 0) begin
      n_fail++;
      $display("[TB] FAIL handover_b_valid: valid=%b queued=%0d, required valid=1", bus.out_valid, exp_q.size());
    end else begin
      exp = exp_q.pop_front();
      n_checks++;
      if (bus.out_data !== exp) begin
        n_fail++;
        $display("[TB] FAIL handover_b_data: data=%h, required %h", bus.out_data, exp);
      end
    end
    bus.req_b = 1'b0;
    tick();
    n_checks++;
    if ({bus.gnt_a, bus.gnt_b} !== 2'b00) begin
      n_fail++;
      $display("[TB] FAIL handover_idle: gnt_a/gnt_b=%b%b, required 00", bus.gnt_a, bus.gnt_b);
    end
  endtask

  task automatic test_tie();
    logic [DATA_W-1:0] exp;
    logic [1:0] want;
    // After a B burst both modes give the tie to A
    bus.req_a = 1'b1; bus.req_b = 1'b1;
    tick();
    n_checks++;
    if ({bus.gnt_a, bus.gnt_b} !== 2'b10) begin
      n_fail++;
      $display("[TB] FAIL tie_after_b: gnt_a/gnt_b=%b%b, required 10", bus.gnt_a, bus.gnt_b);
    end
    bus.req_a = 1'b0; bus.req_b = 1'b0;
    tick();
    bus.req_a = 1'b1;
    tick();
    bus.data_a = 8'h77;
    exp_q.push_back(bus.data_a);
    tick();
    n_checks++;
    if (bus.out_valid !== 1'b1 || exp_q.size() == 0) begin
      n_fail++;
      $display("[TB] FAIL tie_a_burst_valid: valid=%b queued=%0d, required valid=1", bus.out_valid, exp_q.size());
    end else begin
      exp = exp_q.pop_front();
      n_checks++;
      if (bus.out_data !== exp) begin
        n_fail++;
        $display("[TB] FAIL tie_a_burst_data: data=%h, required %h", bus.out_data, exp);
      end
    end
    bus.req_a = 1'b0;
    tick();
    // After an A burst round-robin picks B, fixed priority still picks A
    want = FIXED_PRIO ? 2'b10 : 2'b01;
    bus.req_a = 1'b1; bus.req_b = 1'b1;
    tick();
    n_checks++;
    if ({bus.gnt_a, bus.gnt_b} !== want) begin
      n_fail++;
      $display("[TB] FAIL tie_after_a: gnt_a/gnt_b=%b%b, required %b", bus.gnt_a, bus.gnt_b, want);
    end
    bus.req_a = 1'b0; bus.req_b = 1'b0;
    tick();
  endtask

  task automatic test_unlimited_hold();
    logic [DATA_W-1:0] exp;
    bus0.req_a = 1'b1; bus0.req_b = 1'b0;
    tick();
    n_checks++;
    if ({bus0.gnt_a, bus0.gnt_b} !== 2'b10) begin
      n_fail++;
      $display("[TB] FAIL unlim_grant_a: gnt_a/gnt_b=%b%b, required 10", bus0.gnt_a, bus0.gnt_b);
    end
    bus0.req_b = 1'b1;
    bus0.data_b = 8'hEE;
    for (int i = 0; i < 20; i++) begin
      bus0.data_a = 8'hC0 + 8'(i);
      exp0_q.push_back(bus0.data_a);
      tick();
      n_checks++;
      if ({bus0.gnt_a, bus0.gnt_b, bus0.out_valid} !== 3'b101 || exp0_q.size() == 0) begin
        n_fail++;
        $display("[TB] FAIL unlim_hold %0d: gnt_a/gnt_b/valid=%b%b%b queued=%0d, required 101",
                 i, bus0.gnt_a, bus0.gnt_b, bus0.out_valid, exp0_q.size());
      end else begin
        exp = exp0_q.pop_front();
        n_checks++;
        if (bus0.out_data !== exp) begin
          n_fail++;
          $display("[TB] FAIL unlim_data %0d: data=%h, required %h", i, bus0.out_data, exp);
        end
      end
    end
    bus0.req_a = 1'b0;
    tick();
    n_checks++;
    if ({bus0.gnt_a, bus0.gnt_b} !== 2'b01) begin
      n_fail++;
      $display("[TB] FAIL unlim_to_b: gnt_a/gnt_b=%b%b, required 01", bus0.gnt_a, bus0.gnt_b);
    end
    bus0.data_b = 8'hD1;
    exp0_q.push_back(bus0.data_b);
    tick();
    n_checks++;
    if (bus0.out_valid !== 1'b1 || exp0_q.size() == 0) begin
      n_fail++;
      $display("[TB] FAIL unlim_b_valid: valid=%b queued=%0d, required valid=1", bus0.out_valid, exp0_q.size());
    end else begin
      exp = exp0_q.pop_front();
      n_checks++;
      if (bus0.out_data !== exp) begin
        n_fail++;
        $display("[TB] FAIL unlim_b_data: data=%h, required %h", bus0.out_data, exp);
      end
    end
    bus0.req_b = 1'b0;
    tick();
    n_checks++;
    if ({bus0.gnt_a, bus0.gnt_b} !== 2'b00) begin
      n_fail++;
      $display("[TB] FAIL unlim_idle: gnt_a/gnt_b=%b%b, required 00", bus0.gnt_a, bus0.gnt_b);
    end
  endtask

  task automatic test_drain();
    n_checks++;
    if (exp_q.size() != 0 || exp0_q.size() != 0) begin
      n_fail++;
      $display("[TB] FAIL drain: %0d and %0d beats never emitted, required 0 and 0", exp_q.size(), exp0_q.size());
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail = 0;
    $display("[TB] starting mux_2x1_arbiter bench (fixed priority = %0d)", FIXED_PRIO);
    test_reset();
    test_single_requester();
    test_rotation();
    test_handover();
    test_tie();
    test_unlimited_hold();
    test_drain();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
